// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the signals between two requesters (A = CPU, B = DMA), the
//   arbiter and a single synchronous memory.
//
//   Port A / Port B (x = a|b):
//     x_req    requester -> arbiter   access request, held until x_gnt
//     x_wr     requester -> arbiter   1 = write, 0 = read
//     x_wide   requester -> arbiter   1 = 16-bit, 0 = 8-bit access
//     x_addr   requester -> arbiter   16-bit address
//     x_wdata  requester -> arbiter   16-bit write data
//     x_gnt    arbiter -> requester   access accepted this cycle
//     x_rvalid arbiter -> requester   x_rdata holds read data this cycle
//     x_rdata  arbiter -> requester   16-bit read data
//   Memory:
//     mem_en, mem_wr, mem_wide, mem_addr, mem_din   arbiter -> memory
//     mem_dout                                      memory -> arbiter
//
//   modport slave  : the arbiter's view
//   modport master : the environment's view (requesters plus memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
    logic        a_req;
    logic        a_wr;
    logic        a_wide;
    logic [15:0] a_addr;
    logic [15:0] a_wdata;
    logic        a_gnt;
    logic        a_rvalid;
    logic [15:0] a_rdata;

    logic        b_req;
    logic        b_wr;
    logic        b_wide;
    logic [15:0] b_addr;
    logic [15:0] b_wdata;
    logic        b_gnt;
    logic        b_rvalid;
    logic [15:0] b_rdata;

    logic        mem_en;
    logic        mem_wr;
    logic        mem_wide;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    modport slave (
        input  a_req, a_wr, a_wide, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_wr, b_wide, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_en, mem_wr, mem_wide, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output a_req, a_wr, a_wide, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_wr, b_wide, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_en, mem_wr, mem_wide, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-port arbiter in front of one synchronous memory. Port A (CPU) has
//   priority; port B (DMA) gains priority once it has been denied for
//   MAX_WAIT cycles, which bounds its starvation. Grants and the memory
//   strobe are combinational so a granted access reaches the memory in the
//   same cycle. Memory read data returns one cycle after the strobe and is
//   flagged with rvalid on whichever port issued the read.
//
//   Parameters:
//     MAX_WAIT  denied cycles before port B overrides port A (1..15)
//   Ports:
//     clk    single clock
//     reset  synchronous, active-high reset
//     bus    mem_arbiter_if.slave (port A, port B and memory signals)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    // Saturating 4-bit increment for the starvation counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       rd_pend_q,  rd_pend_d;
    port_e      rd_port_q,  rd_port_d;

    logic        b_prio;
    logic        a_gnt;
    logic        b_gnt;
    logic        mem_wr;
    logic        mem_wide;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;

    // Grant decision. Width flags never take part in it.
    always_comb begin
        b_prio = (wait_cnt_q >= MAX_WAIT_C);
        a_gnt  = 1'b0;
        b_gnt  = 1'b0;
        if (!reset) begin
            if (bus.a_req && !(bus.b_req && b_prio)) begin
                a_gnt = 1'b1;
            end else if (bus.b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    // Memory-side mux: attributes of the winner, all zero when idle.
    always_comb begin
        mem_wr   = 1'b0;
        mem_wide = 1'b0;
        mem_addr = 16'h0000;
        mem_din  = 16'h0000;
        if (a_gnt) begin
            mem_wr   = bus.a_wr;
            mem_wide = bus.a_wide;
            mem_addr = bus.a_addr;
            mem_din  = bus.a_wdata;
        end else if (b_gnt) begin
            mem_wr   = bus.b_wr;
            mem_wide = bus.b_wide;
            mem_addr = bus.b_addr;
            mem_din  = bus.b_wdata;
        end
    end

    // Next state: starvation counter and read-return tracking.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (b_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (bus.b_req) begin
            wait_cnt_d = sat_inc4(wait_cnt_q);
        end
        // Tracking is rewritten every cycle, so back-to-back reads from
        // alternating ports each steer their own return beat.
        rd_pend_d = (a_gnt || b_gnt) && !mem_wr;
        rd_port_d = b_gnt ? PORT_B : PORT_A;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 4'd0;
            rd_pend_q  <= 1'b0;
            rd_port_q  <= PORT_A;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_port_q  <= rd_port_d;
        end
    end

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.mem_en   = a_gnt | b_gnt;
    assign bus.mem_wr   = mem_wr;
    assign bus.mem_wide = mem_wide;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_din  = mem_din;

    // Reset gates rvalid directly so a read granted just before reset
    // asserts never returns.
    assign bus.a_rvalid = !reset && rd_pend_q && (rd_port_q == PORT_A);
    assign bus.b_rvalid = !reset && rd_pend_q && (rd_port_q == PORT_B);

    // The memory output is shared; rvalid qualifies it per port.
    assign bus.a_rdata  = bus.mem_dout;
    assign bus.b_rdata  = bus.mem_dout;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4: cycles port B may be denied before it overrides port A priority; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port a_req, input, 1: port A (CPU) access request.
REQ-005 SHALL have ports a_wr (1, write when 1), a_wide (1; 1 = 16-bit, 0 = 8-bit), a_addr (16) and a_wdata (16), all inputs: port A access attributes.
REQ-006 SHALL have port a_gnt, output, 1: port A access accepted this cycle.
REQ-007 SHALL have port a_rvalid, output, 1: a_rdata holds port A read data this cycle.
REQ-008 SHALL have port a_rdata, output, 16: port A read data.
REQ-009 SHALL have ports b_req, b_wr, b_wide, b_addr, b_wdata, b_gnt, b_rvalid and b_rdata: port B (DMA) equivalents with the same widths and meanings.
REQ-010 SHALL have ports mem_en, mem_wr and mem_wide, outputs, 1 each: memory strobe, write enable and width.
REQ-011 SHALL have ports mem_addr (16) and mem_din (16), outputs: memory address and write data.
REQ-012 SHALL have port mem_dout, input, 16: memory read data, registered by the memory and valid one cycle after a read strobe.

Function
REQ-013 SHALL follow a request/grant handshake: the requester holds x_req high with stable attributes until x_gnt is high; the access completes in the cycle where x_req and x_gnt are both high.
REQ-014 SHALL generate a_gnt, b_gnt and mem_* combinationally from the current requests and registered state, so a granted access takes zero added latency.
REQ-015 SHALL never assert a_gnt and b_gnt in the same cycle.
REQ-016 SHALL never assert x_gnt unless x_req is high.
REQ-017 SHALL grant a sole requester immediately.
REQ-018 SHALL, when both ports request, grant port A unless wait_cnt >= MAX_WAIT, in which case it grants port B.
REQ-019 SHALL keep wait_cnt as a 4-bit register: increment when b_req is high and b_gnt is low, saturating at 15; clear to 0 on b_gnt; hold otherwise.
REQ-020 SHALL drive mem_en = a_gnt | b_gnt.
REQ-021 SHALL drive mem_wr, mem_wide, mem_addr and mem_din from the granted port's attributes, and drive them to 0 when there is no grant.
REQ-022 SHALL, on a granted read (mem_wr = 0), register rd_pend = 1 and rd_port = the granted port; both are updated every cycle.
REQ-023 SHALL assert x_rvalid in the cycle after a granted read, only for the port in rd_port; writes never produce rvalid.
REQ-024 SHALL wire a_rdata and b_rdata directly to mem_dout; the data is meaningful only while the matching rvalid is high.
REQ-025 SHALL support back-to-back grants: a new access may be granted in the same cycle that the previous read's rvalid is high, giving one access per cycle sustained.
REQ-026 SHALL allow alternating grants A, B, A, ..., each read's rvalid going to the correct port.
REQ-027 SHALL not alter the grant decision based on x_wide.
REQ-028 SHALL pass the width flag to mem_wide unchanged.

Reset
REQ-029 SHALL, while reset is high, force a_gnt, b_gnt, mem_en, a_rvalid and b_rvalid to 0 and clear wait_cnt, rd_pend and rd_port.
REQ-030 SHALL, when reset is asserted in the cycle after a granted read, suppress that read's rvalid.
REQ-031 SHALL grant normally from the first cycle after reset deasserts.

Verification
REQ-032 Bench: only a_req read at 0x1234 -> a_gnt = 1 and mem_en = 1 with mem_addr = 0x1234 that cycle; a_rvalid = 1 next cycle with a_rdata = mem_dout; b_rvalid = 0 throughout.
REQ-033 Bench: a_req and b_req both held continuously with MAX_WAIT = 4 -> grants A, A, A, A, B repeating; b_gnt every 5th cycle; never both grants in one cycle.
REQ-034 Bench: b_req write of 0xBEEF at 0x0200 with a_req idle -> b_gnt = 1, mem_wr = 1, mem_din = 0xBEEF, mem_addr = 0x0200 that cycle; no rvalid follows.
REQ-035 Bench: A read then B read on consecutive cycles -> a_rvalid in cycle 2, b_rvalid in cycle 3, each carrying that cycle's mem_dout.
REQ-036 Bench: reset asserted the cycle after a granted A read -> a_rvalid = 0; wait_cnt = 0; after release a lone b_req is granted on the first cycle.
REQ-037 Bench: no requests for 10 cycles -> mem_en = 0, all mem_* outputs = 0, wait_cnt stays 0.
